// File: rtl/mips_multicycle_control_if.sv
// Control/datapath bundle for the multicycle MIPS main controller.
// master = control FSM side, slave = datapath side.
interface mips_multicycle_control_if;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       PCWrite;
    logic       PCWriteCond;
    logic       PCWriteCondNe;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       MemtoReg;
    logic       RegDst;
    logic       RegWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] PCSource;
    logic       aluOP1;
    logic       aluOP2;
    logic       instr_done;
    logic       illegal_op;
    logic [3:0] state_out;

    modport master (
        input  opcode, mem_ready,
        output PCWrite, PCWriteCond, PCWriteCondNe, IorD, MemRead, MemWrite,
               IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSource,
               aluOP1, aluOP2, instr_done, illegal_op, state_out
    );

    modport slave (
        output opcode, mem_ready,
        input  PCWrite, PCWriteCond, PCWriteCondNe, IorD, MemRead, MemWrite,
               IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSource,
               aluOP1, aluOP2, instr_done, illegal_op, state_out
    );
endinterface

// File: rtl/mips_multicycle_control.sv
// Main control FSM of the multicycle MIPS datapath: fetch/decode/execute/
// memory/writeback sequencing with mem_ready stalls and illegal-opcode discard.
module mips_multicycle_control #(
    parameter logic [5:0] OP_RTYPE = 6'b000000,
    parameter logic [5:0] OP_LW    = 6'b100011,
    parameter logic [5:0] OP_SW    = 6'b101011,
    parameter logic [5:0] OP_BEQ   = 6'b000100,
    parameter logic [5:0] OP_BNE   = 6'b000101,
    parameter logic [5:0] OP_J     = 6'b000010
) (
    input  logic                       clk,
    input  logic                       reset,
    mips_multicycle_control_if.master  ctl
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADDR  = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_RWB      = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9
    } state_t;

    state_t     state_q, state_d;
    logic [5:0] op_q, op_d;

    logic       pc_write, pc_wcond, pc_wcond_ne, iord, mem_rd, mem_wr, ir_wr;
    logic       mem2reg, reg_dst, reg_wr, src_a, aop1, aop2, done, illegal;
    logic [1:0] src_b, pc_src;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    // Outputs are forced low while reset is held, whatever state we were in.
    always_comb begin
        state_d     = S_FETCH;
        op_d        = op_q;
        pc_write    = 1'b0;
        pc_wcond    = 1'b0;
        pc_wcond_ne = 1'b0;
        iord        = 1'b0;
        mem_rd      = 1'b0;
        mem_wr      = 1'b0;
        ir_wr       = 1'b0;
        mem2reg     = 1'b0;
        reg_dst     = 1'b0;
        reg_wr      = 1'b0;
        src_a       = 1'b0;
        src_b       = 2'b00;
        pc_src      = 2'b00;
        aop1        = 1'b0;
        aop2        = 1'b0;
        done        = 1'b0;
        illegal     = 1'b0;
        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    mem_rd   = 1'b1;
                    src_b    = 2'b01;
                    ir_wr    = ctl.mem_ready;
                    pc_write = ctl.mem_ready;
                    state_d  = ctl.mem_ready ? S_DECODE : S_FETCH;
                end
                S_DECODE: begin
                    src_b = 2'b11;
                    op_d  = ctl.opcode;
                    case (ctl.opcode)
                        OP_RTYPE:      state_d = S_EXECUTE;
                        OP_LW, OP_SW:  state_d = S_MEMADDR;
                        OP_BEQ, OP_BNE: state_d = S_BRANCH;
                        OP_J:          state_d = S_JUMP;
                        default: begin
                            illegal = 1'b1;
                            state_d = S_FETCH;
                        end
                    endcase
                end
                S_MEMADDR: begin
                    src_a   = 1'b1;
                    src_b   = 2'b10;
                    state_d = (op_q == OP_SW) ? S_MEMWRITE : S_MEMREAD;
                end
                S_MEMREAD: begin
                    mem_rd  = 1'b1;
                    iord    = 1'b1;
                    state_d = ctl.mem_ready ? S_MEMWB : S_MEMREAD;
                end
                S_MEMWB: begin
                    mem2reg = 1'b1;
                    reg_wr  = 1'b1;
                    done    = 1'b1;
                end
                S_MEMWRITE: begin
                    mem_wr  = 1'b1;
                    iord    = 1'b1;
                    done    = ctl.mem_ready;
                    state_d = ctl.mem_ready ? S_FETCH : S_MEMWRITE;
                end
                S_EXECUTE: begin
                    src_a   = 1'b1;
                    aop1    = 1'b1;
                    state_d = S_RWB;
                end
                S_RWB: begin
                    reg_dst = 1'b1;
                    reg_wr  = 1'b1;
                    done    = 1'b1;
                end
                S_BRANCH: begin
                    src_a       = 1'b1;
                    aop2        = 1'b1;
                    pc_src      = 2'b01;
                    pc_wcond    = (op_q == OP_BEQ);
                    pc_wcond_ne = (op_q == OP_BNE);
                    done        = 1'b1;
                end
                S_JUMP: begin
                    pc_src   = 2'b10;
                    pc_write = 1'b1;
                    done     = 1'b1;
                end
                default: state_d = S_FETCH;
            endcase
        end
    end

    assign ctl.PCWrite       = pc_write;
    assign ctl.PCWriteCond   = pc_wcond;
    assign ctl.PCWriteCondNe = pc_wcond_ne;
    assign ctl.IorD          = iord;
    assign ctl.MemRead       = mem_rd;
    assign ctl.MemWrite      = mem_wr;
    assign ctl.IRWrite       = ir_wr;
    assign ctl.MemtoReg      = mem2reg;
    assign ctl.RegDst        = reg_dst;
    assign ctl.RegWrite      = reg_wr;
    assign ctl.ALUSrcA       = src_a;
    assign ctl.ALUSrcB       = src_b;
    assign ctl.PCSource      = pc_src;
    assign ctl.aluOP1        = aop1;
    assign ctl.aluOP2        = aop2;
    assign ctl.instr_done    = done;
    assign ctl.illegal_op    = illegal;
    assign ctl.state_out     = reset ? 4'd0 : state_q;

endmodule
